wb8_arbiter: RTL

Two-master Wishbone8 interconnect: round-robin arbitration between master 0 (CPU bus bridge) and master 1 (DMA / future bus master), registered address decode onto up to NSLAVES slave strobes, and bus-error termination for unmapped addresses and for slaves that never acknowledge. It replaces the combinational per-device strobe/ack/data mux in the board top level. It also records errors for software diagnosis.

---
 rtl/wb8_arbiter_pkg.sv | 30 +++
 rtl/wb8_addr_decode.sv | 31 +++
 rtl/wb8_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb8_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone8 interconnect.
//   - FSM state encoding (IDLE / ACCESS / ERR / HOLD)
//   - default slave address map (index 0 in the least-significant 32 bits)
//   - timeout counter and slave-select widths
//   - saturating 8-bit increment used by the error counter
package wb8_arbiter_pkg;

  localparam int unsigned TMO_W = 8;
  // Wide enough for the largest supported slave count (8).
  localparam int unsigned SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Default map, slave 0 in bits [31:0]:
  //   s0 FFFFFFF0-FFFFFFFF, s1 FFFFF800-FFFFF8FF, s2 FFFFF000-FFFFF7FF, s3 FFFF0000-FFFF1FFF
  localparam logic [127:0] DEF_SLAVE_BASE =
    {32'hFFFF0000, 32'hFFFFF000, 32'hFFFFF800, 32'hFFFFFFF0};
  localparam logic [127:0] DEF_SLAVE_MASK =
    {32'hFFFFE000, 32'hFFFFF800, 32'hFFFFFF00, 32'hFFFFFFF0};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb8_addr_decode.sv
// Combinational base/mask address decoder with lowest-index priority.
// Ports:
//   I_adr  - address to decode
//   O_sel  - index of the matching slave (0 when no slave matches)
//   O_miss - no slave matches I_adr
module wb8_addr_decode
  import wb8_arbiter_pkg::*;
#(
  parameter int unsigned                NSLAVES    = 4,
  parameter logic [32*NSLAVES-1:0]      SLAVE_BASE = (32*NSLAVES)'(DEF_SLAVE_BASE),
  parameter logic [32*NSLAVES-1:0]      SLAVE_MASK = (32*NSLAVES)'(DEF_SLAVE_MASK)
) (
  input  logic [31:0] I_adr,
  output sel_t        O_sel,
  output logic        O_miss
);

  always_comb begin
    O_sel  = '0;
    O_miss = 1'b1;
    // Scan high to low so the lowest matching index is the one left standing.
    for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
      if ((I_adr & SLAVE_MASK[32*i +: 32]) ==
          (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
        O_sel  = sel_t'(i);
        O_miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb8_arbiter.sv
// Two-master Wishbone8 interconnect: round-robin arbitration, registered address
// decode onto NSLAVES one-hot slave strobes, and error termination for unmapped
// addresses and for slaves that do not acknowledge within TIMEOUT_CYCLES.
// Ports:
//   I_wb_clk, I_reset_n            - clock, asynchronous active-low reset
//   I_mX_cyc/stb/we/adr/dat        - master X request (X = 0 CPU bridge, 1 DMA)
//   O_mX_dat/ack/err               - master X response; err qualifies ack
//   O_s_stb/we/adr/dat             - shared slave bus, one-hot strobe
//   I_s_ack, I_s_dat               - per-slave ack and packed read data
//   O_err_count, O_err_adr         - saturating error count, last error address
module wb8_arbiter
  import wb8_arbiter_pkg::*;
#(
  parameter int unsigned           NSLAVES        = 4,
  parameter logic [32*NSLAVES-1:0] SLAVE_BASE     = (32*NSLAVES)'(DEF_SLAVE_BASE),
  parameter logic [32*NSLAVES-1:0] SLAVE_MASK     = (32*NSLAVES)'(DEF_SLAVE_MASK),
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [7:0]            ERR_DATA       = 8'h00
) (
  input  logic                   I_wb_clk,
  input  logic                   I_reset_n,
  input  logic                   I_m0_cyc,
  input  logic                   I_m0_stb,
  input  logic                   I_m0_we,
  input  logic [31:0]            I_m0_adr,
  input  logic [7:0]             I_m0_dat,
  input  logic                   I_m1_cyc,
  input  logic                   I_m1_stb,
  input  logic                   I_m1_we,
  input  logic [31:0]            I_m1_adr,
  input  logic [7:0]             I_m1_dat,
  output logic [7:0]             O_m0_dat,
  output logic                   O_m0_ack,
  output logic                   O_m0_err,
  output logic [7:0]             O_m1_dat,
  output logic                   O_m1_ack,
  output logic                   O_m1_err,
  output logic [NSLAVES-1:0]     O_s_stb,
  output logic                   O_s_we,
  output logic [31:0]            O_s_adr,
  output logic [7:0]             O_s_dat,
  input  logic [NSLAVES-1:0]     I_s_ack,
  input  logic [8*NSLAVES-1:0]   I_s_dat,
  output logic [7:0]             O_err_count,
  output logic [31:0]            O_err_adr
);

  logic [1:0]       r_state, w_state_nxt;
  logic             r_gnt, w_gnt_nxt;
  logic             r_last, w_last_nxt;
  sel_t             r_sel, w_sel_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [7:0]       r_err_count, w_err_count_nxt;
  logic [31:0]      r_err_adr, w_err_adr_nxt;

  logic        w_req0, w_req1;
  logic        w_arb_gnt;
  logic        w_g_cyc, w_g_stb, w_g_we, w_g_req;
  logic [31:0] w_g_adr;
  logic [7:0]  w_g_dat;
  logic [31:0] w_dec_adr;
  sel_t        w_dec_sel;
  logic        w_dec_miss;
  logic        w_sack;
  logic [7:0]  w_sdat;
  logic        w_held, w_in_access, w_in_err;
  logic        w_ack_ok, w_tmo_hit, w_strobe;
  logic        w_m_ack;
  logic [7:0]  w_m_dat;

  assign w_req0 = I_m0_cyc & I_m0_stb;
  assign w_req1 = I_m1_cyc & I_m1_stb;

  // Tie goes to whoever did not have the previous grant.
  assign w_arb_gnt = (w_req0 & w_req1) ? ~r_last : w_req1;

  assign w_g_cyc = r_gnt ? I_m1_cyc : I_m0_cyc;
  assign w_g_stb = r_gnt ? I_m1_stb : I_m0_stb;
  assign w_g_we  = r_gnt ? I_m1_we  : I_m0_we;
  assign w_g_adr = r_gnt ? I_m1_adr : I_m0_adr;
  assign w_g_dat = r_gnt ? I_m1_dat : I_m0_dat;
  assign w_g_req = w_g_cyc & w_g_stb;

  // In IDLE the grant is not registered yet, so decode the master about to win.
  assign w_dec_adr = (r_state == ST_IDLE) ? (w_arb_gnt ? I_m1_adr : I_m0_adr) : w_g_adr;

  wb8_addr_decode #(
    .NSLAVES    (NSLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .I_adr  (w_dec_adr),
    .O_sel  (w_dec_sel),
    .O_miss (w_dec_miss)
  );

  always_comb begin
    w_sack = 1'b0;
    w_sdat = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      if (r_sel == sel_t'(i)) begin
        w_sack = I_s_ack[i];
        w_sdat = I_s_dat[8*i +: 8];
      end
    end
  end

  assign w_held      = (r_state != ST_IDLE);
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_in_err    = (r_state == ST_ERR);
  assign w_ack_ok    = w_in_access & w_g_req & w_sack;
  // Last permitted ACCESS cycle; an ack arriving in it still wins.
  assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_strobe    = w_in_access & w_g_req;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_last_nxt      = r_last;
    w_sel_nxt       = r_sel;
    w_tmo_nxt       = r_tmo;
    w_err_count_nxt = r_err_count;
    w_err_adr_nxt   = r_err_adr;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          w_gnt_nxt   = w_arb_gnt;
          w_last_nxt  = w_arb_gnt;
          w_sel_nxt   = w_dec_sel;
          w_tmo_nxt   = '0;
          w_state_nxt = w_dec_miss ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!w_g_cyc) begin
          w_tmo_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_ack_ok) begin
          w_tmo_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end else if (w_tmo_hit) begin
          w_tmo_nxt   = '0;
          w_state_nxt = ST_ERR;
        end else begin
          w_tmo_nxt   = r_tmo + TMO_W'(1);
        end
      end
      ST_ERR: begin
        w_err_count_nxt = sat_inc8(r_err_count);
        w_err_adr_nxt   = w_g_adr;
        w_state_nxt     = ST_HOLD;
      end
      default: begin  // ST_HOLD: bus stays locked to the granted master
        if (!w_g_cyc) begin
          w_state_nxt = ST_IDLE;
        end else if (w_g_stb) begin
          w_sel_nxt   = w_dec_sel;
          w_tmo_nxt   = '0;
          w_state_nxt = w_dec_miss ? ST_ERR : ST_ACCESS;
        end
      end
    endcase
  end

  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 1'b0;
      r_last      <= 1'b1;
      r_sel       <= '0;
      r_tmo       <= '0;
      r_err_count <= '0;
      r_err_adr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_last      <= w_last_nxt;
      r_sel       <= w_sel_nxt;
      r_tmo       <= w_tmo_nxt;
      r_err_count <= w_err_count_nxt;
      r_err_adr   <= w_err_adr_nxt;
    end
  end

  always_comb begin
    O_s_stb = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      O_s_stb[i] = w_strobe & (r_sel == sel_t'(i));
    end
  end

  assign O_s_we  = w_held ? w_g_we  : 1'b0;
  assign O_s_adr = w_held ? w_g_adr : 32'h0;
  assign O_s_dat = w_held ? w_g_dat : 8'h0;

  assign w_m_ack = w_ack_ok | w_in_err;
  assign w_m_dat = w_in_err ? ERR_DATA : (w_in_access ? w_sdat : 8'h0);

  assign O_m0_ack = w_held & ~r_gnt & w_m_ack;
  assign O_m0_err = w_held & ~r_gnt & w_in_err;
  assign O_m0_dat = (w_held & ~r_gnt) ? w_m_dat : 8'h0;
  assign O_m1_ack = w_held & r_gnt & w_m_ack;
  assign O_m1_err = w_held & r_gnt & w_in_err;
  assign O_m1_dat = (w_held & r_gnt) ? w_m_dat : 8'h0;

  assign O_err_count = r_err_count;
  assign O_err_adr   = r_err_adr;

endmodule
